// File: rtl/flash_ctrl_fsm.sv
// rtl/flash_ctrl_fsm.sv - single-word read/program sequencer for a 16-bit NOR-style flash
module flash_ctrl_fsm #(
  parameter int ADDR_W     = 22,
  parameter int RD_WAIT    = 4,
  parameter int WR_TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic              clear,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              wr_err,
  output logic [15:0]       rd_data,
  output logic [11:0]       state,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_dq_out,
  output logic              mem_dq_oe,
  input  logic [15:0]       mem_dq_in,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  input  logic              mem_ry_by
);

  localparam int CNT_MAX = (RD_WAIT > WR_TIMEOUT) ? RD_WAIT : WR_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_TIMEOUT - 1);

  typedef enum logic [11:0] {
    S_IDLE       = 12'h001,
    S_READ_ST0   = 12'h002,
    S_READ_ST1   = 12'h004,
    S_READ_ST2   = 12'h008,
    S_READ_WAIT  = 12'h010,
    S_READ_DONE  = 12'h020,
    S_WRITE_ST0  = 12'h040,
    S_WRITE_ST1  = 12'h080,
    S_WRITE_ST2  = 12'h100,
    S_WRITE_ST3  = 12'h200,
    S_WRITE_ST4  = 12'h400,
    S_WRITE_WAIT = 12'h800
  } state_t;

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic              accept, rd_capture, done_d, err_set;
  logic              ce_n_d, oe_n_d, we_n_d, dq_oe_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [15:0]       mem_dq_d;

  assign state = state_q;
  assign busy  = !(state_q == S_IDLE || state_q == S_READ_DONE);

  // Next-state, counter and phase logic; the wait counter only decrements when nonzero.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    rd_capture = 1'b0;
    done_d     = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      S_IDLE, S_READ_DONE: begin
        if (rd_req) begin
          state_d = S_READ_ST0;
          accept  = 1'b1;
        end else if (wr_req) begin
          state_d = S_WRITE_ST0;
          phase_d = 1'b0;
          accept  = 1'b1;
        end else if (state_q == S_READ_DONE && clear) begin
          state_d = S_IDLE;
        end
      end
      S_READ_ST0: state_d = S_READ_ST1;
      S_READ_ST1: state_d = S_READ_ST2;
      S_READ_ST2: begin
        cnt_d   = RD_LOAD;
        state_d = S_READ_WAIT;
      end
      S_READ_WAIT: begin
        if (cnt_q == '0) begin
          state_d    = S_READ_DONE;
          rd_capture = 1'b1;
          done_d     = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WRITE_ST0, S_WRITE_ST1, S_WRITE_ST2, S_WRITE_ST3: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          case (state_q)
            S_WRITE_ST0: state_d = S_WRITE_ST1;
            S_WRITE_ST1: state_d = S_WRITE_ST2;
            S_WRITE_ST2: state_d = S_WRITE_ST3;
            default:     state_d = S_WRITE_ST4;
          endcase
        end
      end
      S_WRITE_ST4: begin
        cnt_d   = WR_LOAD;
        state_d = S_WRITE_WAIT;
      end
      S_WRITE_WAIT: begin
        // The counter still holding its load value marks the first cycle, where ry_by is ignored.
        if (cnt_q != WR_LOAD && mem_ry_by) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory pin values set up by the current state; they are registered so strobes never glitch.
  always_comb begin
    ce_n_d     = 1'b1;
    oe_n_d     = 1'b1;
    we_n_d     = 1'b1;
    dq_oe_d    = 1'b0;
    mem_addr_d = mem_addr;
    mem_dq_d   = mem_dq_out;
    case (state_q)
      S_READ_ST0: begin
        ce_n_d     = 1'b0;
        mem_addr_d = addr_q;
      end
      S_READ_ST1, S_READ_ST2: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      S_READ_WAIT: begin
        ce_n_d = (cnt_q == '0);
        oe_n_d = (cnt_q == '0);
      end
      S_WRITE_ST0, S_WRITE_ST1, S_WRITE_ST2, S_WRITE_ST3: begin
        ce_n_d  = 1'b0;
        we_n_d  = phase_q;
        dq_oe_d = 1'b1;
        if (!phase_q) begin
          case (state_q)
            S_WRITE_ST0: begin mem_addr_d = ADDR_W'(12'h555); mem_dq_d = 16'h00AA; end
            S_WRITE_ST1: begin mem_addr_d = ADDR_W'(12'h2AA); mem_dq_d = 16'h0055; end
            S_WRITE_ST2: begin mem_addr_d = ADDR_W'(12'h555); mem_dq_d = 16'h00A0; end
            default:     begin mem_addr_d = addr_q;           mem_dq_d = data_q;    end
          endcase
        end
      end
      default: ;
    endcase
  end

  // Control state, latched request, status flags and registered memory pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      cnt_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      rd_data    <= '0;
      done       <= 1'b0;
      wr_err     <= 1'b0;
      mem_addr   <= '0;
      mem_dq_out <= '0;
      mem_dq_oe  <= 1'b0;
      mem_ce_n   <= 1'b1;
      mem_oe_n   <= 1'b1;
      mem_we_n   <= 1'b1;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      cnt_q      <= cnt_d;
      done       <= done_d;
      if (accept) begin
        addr_q <= addr;
        data_q <= wr_data;
        wr_err <= 1'b0;
      end else if (err_set) begin
        wr_err <= 1'b1;
      end
      if (rd_capture) rd_data <= mem_dq_in;
      mem_addr   <= mem_addr_d;
      mem_dq_out <= mem_dq_d;
      mem_dq_oe  <= dq_oe_d;
      mem_ce_n   <= ce_n_d;
      mem_oe_n   <= oe_n_d;
      mem_we_n   <= we_n_d;
    end
  end

endmodule

// File: tb/tb_flash_ctrl_fsm.sv
// tb/tb_flash_ctrl_fsm.sv - directed self-checking bench for flash_ctrl_fsm
module tb_flash_ctrl_fsm;

  logic        clk, rst_n, rd_req, wr_req, clear;
  logic [21:0] addr;
  logic [15:0] wr_data;
  logic        busy, done, wr_err;
  logic [15:0] rd_data;
  logic [11:0] state;
  logic [21:0] mem_addr;
  logic [15:0] mem_dq_out, mem_dq_in;
  logic        mem_dq_oe, mem_ce_n, mem_oe_n, mem_we_n, mem_ry_by;

  int n_cmp = 0;
  int n_err = 0;

  flash_ctrl_fsm #(.ADDR_W(22), .RD_WAIT(4), .WR_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .wr_req(wr_req), .clear(clear),
    .addr(addr), .wr_data(wr_data), .busy(busy), .done(done), .wr_err(wr_err),
    .rd_data(rd_data), .state(state), .mem_addr(mem_addr), .mem_dq_out(mem_dq_out),
    .mem_dq_oe(mem_dq_oe), .mem_dq_in(mem_dq_in), .mem_ce_n(mem_ce_n),
    .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n), .mem_ry_by(mem_ry_by)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [11:0] s, input int max);
    int i = 0;
    while (state !== s && i < max) begin
      tick();
      i++;
    end
    if (state !== s) check(tag, 32'(state), 32'(s));
  endtask

  // Directed stimulus with hand-derived expectations
  initial begin
    logic [11:0] rd_seq [7];
    logic [21:0] exp_a  [4];
    logic [15:0] exp_d  [4];
    logic [21:0] got_a  [4];
    logic [15:0] got_d  [4];
    int          oe_low, npulse, nwait;

    rd_seq = '{12'h004, 12'h008, 12'h010, 12'h010, 12'h010, 12'h010, 12'h020};
    exp_a  = '{22'h555, 22'h2AA, 22'h555, 22'h010};
    exp_d  = '{16'h00AA, 16'h0055, 16'h00A0, 16'h1234};
    got_a  = '{default: '0};
    got_d  = '{default: '0};

    rst_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0; clear = 1'b0;
    addr = '0; wr_data = '0; mem_dq_in = '0; mem_ry_by = 1'b0;
    repeat (3) tick();
    check("rst_state", 32'(state), 32'h001);
    check("rst_strobes", {29'd0, mem_ce_n, mem_oe_n, mem_we_n}, 32'h7);
    check("rst_dq_oe", 32'(mem_dq_oe), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst_busy_done_err", {29'd0, busy, done, wr_err}, 32'h0);
    rst_n = 1'b1;
    tick();
    check("post_rst_state", 32'(state), 32'h001);

    // Read of 0x01234 returning 0xBEEF
    addr = 22'h01234; mem_dq_in = 16'hBEEF; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("rd_st0", 32'(state), 32'h002);
    check("rd_busy", 32'(busy), 32'h1);
    oe_low = 0;
    for (int k = 0; k < 7; k++) begin
      tick();
      check($sformatf("rd_seq%0d", k), 32'(state), 32'(rd_seq[k]));
      if (mem_oe_n == 1'b0) oe_low++;
      if (k == 0) begin
        check("rd_addr", 32'(mem_addr), 32'h01234);
        check("rd_ce", 32'(mem_ce_n), 32'h0);
      end
    end
    check("rd_oe_low_cycles", 32'(oe_low), 32'd5);
    check("rd_done", 32'(done), 32'h1);
    check("rd_data", 32'(rd_data), 32'hBEEF);
    check("rd_done_strobes", {30'd0, mem_ce_n, mem_oe_n}, 32'h3);
    tick();
    check("rd_done_pulse", 32'(done), 32'h0);
    check("rd_hold", 32'(state), 32'h020);
    check("rd_not_busy", 32'(busy), 32'h0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("rd_clear", 32'(state), 32'h001);

    // Program 0x1234 at 0x00010; ready asserted in the first wait cycle must be ignored
    addr = 22'h00010; wr_data = 16'h1234; mem_ry_by = 1'b0; wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    check("wr_st0", 32'(state), 32'h040);
    npulse = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (mem_we_n == 1'b0) begin
        if (npulse < 4) begin
          got_a[npulse] = mem_addr;
          got_d[npulse] = mem_dq_out;
          check($sformatf("wr_dq_oe%0d", npulse), 32'(mem_dq_oe), 32'h1);
        end
        npulse++;
      end
      if (state == 12'h800) break;
    end
    check("wr_pulses", 32'(npulse), 32'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("wr_addr%0d", k), 32'(got_a[k]), 32'(exp_a[k]));
      check($sformatf("wr_data%0d", k), 32'(got_d[k]), 32'(exp_d[k]));
    end
    check("wr_wait_state", 32'(state), 32'h800);
    check("wr_wait_bus", {28'd0, mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe}, 32'hE);
    mem_ry_by = 1'b1;
    tick();
    check("wr_ry_first_ignored", 32'(state), 32'h800);
    tick();
    mem_ry_by = 1'b0;
    check("wr_end_state", 32'(state), 32'h001);
    check("wr_done", 32'(done), 32'h1);
    check("wr_no_err", 32'(wr_err), 32'h0);

    // Program timeout
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    wait_state("to_enter_wait", 12'h800, 40);
    nwait = 0;
    while (state === 12'h800 && nwait < 20) begin
      nwait++;
      tick();
    end
    check("to_wait_cycles", 32'(nwait), 32'd8);
    check("to_state", 32'(state), 32'h001);
    check("to_err", 32'(wr_err), 32'h1);
    check("to_done", 32'(done), 32'h1);
    tick();
    check("to_done_pulse", 32'(done), 32'h0);
    check("to_err_sticky", 32'(wr_err), 32'h1);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("to_err_cleared", 32'(wr_err), 32'h0);
    check("to_rd_st0", 32'(state), 32'h002);
    wait_state("to_rd_done", 12'h020, 20);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Both requests: read wins; a write pulse during READ_WAIT is dropped
    rd_req = 1'b1; wr_req = 1'b1;
    tick();
    rd_req = 1'b0; wr_req = 1'b0;
    check("both_rd_wins", 32'(state), 32'h002);
    wait_state("both_reach_wait", 12'h010, 10);
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    check("wr_in_wait_ignored", 32'(state), 32'h010);
    wait_state("both_rd_done", 12'h020, 10);
    tick();
    check("both_stays_done", 32'(state), 32'h020);

    // Accept beats clear in READ_DONE
    clear = 1'b1; rd_req = 1'b1;
    tick();
    clear = 1'b0; rd_req = 1'b0;
    check("clear_vs_accept", 32'(state), 32'h002);
    wait_state("cva_done", 12'h020, 20);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("cva_idle", 32'(state), 32'h001);

    // Asynchronous reset while WRITE_ST1 has write enable low
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    repeat (3) tick();
    check("mid_state", 32'(state), 32'h080);
    check("mid_we_low", 32'(mem_we_n), 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_bus", {28'd0, mem_ce_n, mem_oe_n, mem_we_n, mem_dq_oe}, 32'hE);
    check("async_rst_state", 32'(state), 32'h001);
    check("async_rst_addr", 32'(mem_addr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("after_rst_state", 32'(state), 32'h001);
    check("after_rst_busy", 32'(busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
